// File: rtl/boot_loader_ctrl_if.sv
// Loader link and instruction-ROM write port bundle for boot_loader_ctrl.
//   in_data/in_valid/in_ready : byte stream from the UART/debug bridge
//   rom_wr_en/addr/data       : one-cycle word write strobe into instruction ROM
// master: loader/ROM side (drives bytes, observes writes)
// slave : boot_loader_ctrl side (accepts bytes, drives writes)
interface boot_loader_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rom_wr_en;
  logic [ADDR_W-1:0] rom_wr_addr;
  logic [WIDTH-1:0]  rom_wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, rom_wr_en, rom_wr_addr, rom_wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, rom_wr_en, rom_wr_addr, rom_wr_data
  );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot-time sequencer: holds the core in reset, loads an image
// (header word count N, N words, 32-bit additive checksum; all little-endian
// byte streams) into instruction ROM, verifies the checksum, then releases
// the core.
//   CLOCK, RESET  : system clock, synchronous active-high reset
//   boot_bypass   : skip loading and release the core immediately
//   bus (slave)   : loader byte link and ROM write port
//   core_reset    : active-high reset to the core
//   load_done     : image loaded and verified (sticky)
//   load_error    : bad header or checksum mismatch (sticky)
module boot_loader_ctrl #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               boot_bypass,
  boot_loader_ctrl_if.slave  bus,
  output logic               core_reset,
  output logic               load_done,
  output logic               load_error
);
  localparam int CW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {HDR, DATA, SUM, CHECK, DONE, ERROR} state_t;

  state_t           state, state_n;
  logic [1:0]       byte_cnt;
  logic [CW-1:0]    word_cnt;
  logic [CW-1:0]    word_num;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] exp_sum;

  logic             ready_c;
  logic             take;
  logic             last_byte;
  logic [WIDTH-1:0] word;

  always_comb begin
    ready_c = 1'b0;
    case (state)
      // Once a header byte is in, bypass is no longer honoured.
      HDR:       ready_c = !boot_bypass || (byte_cnt != 2'd0);
      DATA, SUM: ready_c = 1'b1;
      default:   ready_c = 1'b0;
    endcase
  end

  assign bus.in_ready = ready_c;
  assign take         = bus.in_valid && ready_c;
  assign last_byte    = take && (byte_cnt == 2'd3);
  // New byte enters at the top so the first byte ends up in [7:0].
  assign word         = {bus.in_data, shift_q[WIDTH-1:8]};

  always_comb begin
    state_n = state;
    case (state)
      HDR: begin
        if (boot_bypass && (byte_cnt == 2'd0))
          state_n = DONE;
        else if (last_byte) begin
          if ((word == '0) || (word > WIDTH'(DEPTH_WORDS)))
            state_n = ERROR;
          else
            state_n = DATA;
        end
      end
      DATA: begin
        if (last_byte && (word_cnt == word_num - CW'(1)))
          state_n = SUM;
      end
      SUM: begin
        if (last_byte)
          state_n = CHECK;
      end
      CHECK:   state_n = (acc == exp_sum) ? DONE : ERROR;
      default: state_n = state;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state           <= HDR;
      byte_cnt        <= '0;
      word_cnt        <= '0;
      word_num        <= '0;
      shift_q         <= '0;
      acc             <= '0;
      exp_sum         <= '0;
      bus.rom_wr_en   <= 1'b0;
      bus.rom_wr_addr <= '0;
      bus.rom_wr_data <= '0;
      core_reset      <= 1'b1;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
    end else begin
      state         <= state_n;
      bus.rom_wr_en <= 1'b0;
      if (take) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift_q  <= word;
      end
      if (last_byte) begin
        case (state)
          HDR:  word_num <= CW'(word);
          DATA: begin
            bus.rom_wr_en   <= 1'b1;
            bus.rom_wr_addr <= ADDR_W'({word_cnt, 2'b00});
            bus.rom_wr_data <= word;
            acc             <= acc + word;
            word_cnt        <= word_cnt + CW'(1);
          end
          SUM:     exp_sum <= word;
          default: ;
        endcase
      end
      // Status flags follow the next state so they change on the entry edge.
      core_reset <= (state_n != DONE);
      load_done  <= (state_n == DONE);
      load_error <= (state_n == ERROR);
    end
  end
endmodule

// File: tb/tb_boot_loader_ctrl.sv
module tb_boot_loader_ctrl;
  localparam int DEPTH = 1024;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic boot_bypass = 1'b0;
  logic core_reset, load_done, load_error;

  boot_loader_ctrl_if #(.WIDTH(32), .ADDR_W(32)) bif ();

  boot_loader_ctrl #(.WIDTH(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .boot_bypass (boot_bypass),
    .bus         (bif.slave),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 CLOCK = ~CLOCK;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] img[$];

  always @(negedge CLOCK) begin
    if (bif.rom_wr_en) begin
      wr_addr_q.push_back(bif.rom_wr_addr);
      wr_data_q.push_back(bif.rom_wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic byp);
    @(negedge CLOCK);
    RESET        = 1'b1;
    boot_bypass  = byp;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    check_vec("rst_core_reset", core_reset, 1);
    check_vec("rst_load_done", load_done, 0);
    check_vec("rst_load_error", load_error, 0);
    check_vec("rst_wr_en", bif.rom_wr_en, 0);
    check_vec("rst_wr_addr", bif.rom_wr_addr, 0);
    check_vec("rst_wr_data", bif.rom_wr_data, 0);
    check_vec("rst_in_ready", bif.in_ready, !byp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) begin
      int n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge CLOCK);
        bif.in_valid = 1'b0;
      end
    end
    @(negedge CLOCK);
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    while (!bif.in_ready && t < 100) begin
      @(negedge CLOCK);
      t++;
    end
    check_vec("byte_in_ready", bif.in_ready, 1);
    @(posedge CLOCK);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic send_image(input logic [31:0] n, input logic [31:0] sum, input bit gaps);
    send_word(n, gaps);
    for (int k = 0; k < img.size(); k++) send_word(img[k], gaps);
    send_word(sum, gaps);
  endtask

  // Entered just after the edge taking the last checksum byte.
  task automatic check_finish(input bit ok);
    @(negedge CLOCK);
    bif.in_valid = 1'b0;
    check_vec("chk_cycle_core_reset", core_reset, 1);
    check_vec("chk_cycle_load_done", load_done, 0);
    check_vec("chk_cycle_in_ready", bif.in_ready, 0);
    @(negedge CLOCK);
    check_vec("end_core_reset", core_reset, !ok);
    check_vec("end_load_done", load_done, ok);
    check_vec("end_load_error", load_error, !ok);
    check_vec("end_in_ready", bif.in_ready, 0);
  endtask

  // Offer bytes while the block is idle; none may be taken or written.
  task automatic poke_idle(input int expect_writes);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      bif.in_valid = 1'b1;
      bif.in_data  = 8'h5A;
      check_vec("idle_in_ready", bif.in_ready, 0);
    end
    @(negedge CLOCK);
    bif.in_valid = 1'b0;
    check_vec("idle_wr_count", wr_addr_q.size(), expect_writes);
  endtask

  task automatic check_writes(input int n);
    check_vec("wr_count", wr_addr_q.size(), n);
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      check_vec("wr_addr", wr_addr_q[k], k * 4);
      check_vec("wr_data", wr_data_q[k], img[k]);
    end
  endtask

  task automatic bad_header(input logic [31:0] n);
    do_reset(1'b0);
    send_word(n, 1'b0);
    @(negedge CLOCK);
    bif.in_valid = 1'b0;
    check_vec("badhdr_load_error", load_error, 1);
    check_vec("badhdr_core_reset", core_reset, 1);
    check_vec("badhdr_load_done", load_done, 0);
    check_vec("badhdr_in_ready", bif.in_ready, 0);
    poke_idle(0);
  endtask

  logic [31:0] sum;

  initial begin
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;

    // Bypass straight out of reset
    do_reset(1'b1);
    @(negedge CLOCK);
    check_vec("byp_core_reset", core_reset, 0);
    check_vec("byp_load_done", load_done, 1);
    check_vec("byp_load_error", load_error, 0);
    check_vec("byp_in_ready", bif.in_ready, 0);
    boot_bypass = 1'b0;
    poke_idle(0);

    // Normal back-to-back load
    do_reset(1'b0);
    img = '{32'h0000_0013, 32'h0010_0093};
    send_image(32'd2, 32'h0010_00A6, 1'b0);
    check_finish(1'b1);
    check_writes(2);
    poke_idle(2);

    // Checksum mismatch
    do_reset(1'b0);
    send_image(32'd2, 32'h0010_00A7, 1'b0);
    check_finish(1'b0);
    check_writes(2);
    poke_idle(2);

    // Header bounds
    bad_header(32'd0);
    bad_header(DEPTH + 1);

    do_reset(1'b0);
    img.delete();
    sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      img.push_back((k * 32'h0101_0101) ^ 32'hA5C3_0F1E);
      sum = sum + img[k];
    end
    send_image(DEPTH, sum, 1'b0);
    check_finish(1'b1);
    check_writes(DEPTH);

    // Stalls and checksum wrap past 2^32
    do_reset(1'b0);
    img = '{32'hFFFF_FFFF, 32'h0000_0002};
    send_image(32'd2, 32'h0000_0001, 1'b1);
    check_finish(1'b1);
    check_writes(2);

    // Reset lands on the 4th byte of word 1
    do_reset(1'b0);
    img = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    send_word(32'd3, 1'b0);
    send_word(img[0], 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h22, 1'b0);
    @(negedge CLOCK);
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h22;
    RESET        = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    RESET        = 1'b0;
    bif.in_valid = 1'b0;
    check_vec("midrst_wr_en", bif.rom_wr_en, 0);
    check_vec("midrst_wr_addr", bif.rom_wr_addr, 0);
    check_vec("midrst_wr_data", bif.rom_wr_data, 0);
    check_vec("midrst_core_reset", core_reset, 1);
    check_vec("midrst_load_done", load_done, 0);
    check_vec("midrst_load_error", load_error, 0);
    check_vec("midrst_in_ready", bif.in_ready, 1);
    check_vec("midrst_wr_count", wr_addr_q.size(), 1);
    check_vec("midrst_wr0_data", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD_BEEF, 32'h1111_1111);
    wr_addr_q.delete();
    wr_data_q.delete();
    send_image(32'd3, 32'h6666_6666, 1'b0);
    check_finish(1'b1);
    check_writes(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
